// File: rtl/button_event_ctrl.sv
// Turns a debounced button level into SHORT / LONG / DOUBLE press events.
// One event is held in a valid/ack register. Losing an unacknowledged event sets a sticky overrun flag.
module button_event_ctrl #(
    parameter int LONG_PRESS_COUNT = 1_200_000,
    parameter int DOUBLE_GAP_COUNT = 3_600_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_sig,
    output logic       pressed,
    output logic       event_valid,
    output logic [1:0] event_code,
    input  logic       event_ack,
    output logic       overrun
);

    localparam int MAX_COUNT = (LONG_PRESS_COUNT > DOUBLE_GAP_COUNT) ? LONG_PRESS_COUNT
                                                                     : DOUBLE_GAP_COUNT;
    localparam int CNT_W = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_COUNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_COUNT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRESSED   = 3'd1;
    localparam logic [2:0] LONG_HELD = 3'd2;
    localparam logic [2:0] WAIT_2ND  = 3'd3;
    localparam logic [2:0] PRESS_2ND = 3'd4;

    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_DOUBLE = 2'b11;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             emit;
    logic [1:0]       emit_code;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        emit_code = 2'b00;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_sig) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end
                end
                PRESSED: begin
                    // A release always wins over the LONG threshold on the same edge.
                    if (!in_sig) begin
                        state_nxt = WAIT_2ND;
                        cnt_nxt   = '0;
                    end else if (cnt == LONG_LAST) begin
                        emit      = 1'b1;
                        emit_code = EV_LONG;
                        state_nxt = LONG_HELD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                LONG_HELD: begin
                    if (!in_sig) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_2ND: begin
                    if (in_sig) begin
                        state_nxt = PRESS_2ND;
                        cnt_nxt   = '0;
                    end else if (cnt == GAP_LAST) begin
                        emit      = 1'b1;
                        emit_code = EV_SHORT;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                PRESS_2ND: begin
                    if (!in_sig) begin
                        emit      = 1'b1;
                        emit_code = EV_DOUBLE;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pressed <= in_sig;
        end
    end

    // A fresh event always replaces the pending one; overrun records only unacked losses.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            event_valid <= 1'b0;
            event_code  <= 2'b00;
            overrun     <= 1'b0;
        end else if (emit) begin
            event_valid <= 1'b1;
            event_code  <= emit_code;
            if (event_valid) overrun <= !event_ack;
        end else if (event_valid && event_ack) begin
            event_valid <= 1'b0;
            event_code  <= 2'b00;
            overrun     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: reset sequence, table of press scenarios, then random presses
// compared cycle by cycle against a timestamp-based reference model.
module tb_button_event_ctrl;

    localparam int LONG_N = 100;
    localparam int GAP_N  = 40;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b1;
    logic       in_sig  = 1'b0;
    logic       event_ack = 1'b0;
    logic       pressed, event_valid, overrun;
    logic [1:0] event_code;

    button_event_ctrl #(.LONG_PRESS_COUNT(LONG_N), .DOUBLE_GAP_COUNT(GAP_N)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .in_sig(in_sig), .pressed(pressed),
        .event_valid(event_valid), .event_code(event_code), .event_ack(event_ack),
        .overrun(overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       in;
        logic       en;
        logic       ack;
        int         n;
        logic       ev;
        logic [1:0] code;
        logic       ov;
        logic       pr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic i, input logic e, input logic a, input int n,
                                input logic ev, input logic [1:0] c, input logic ov,
                                input logic pr);
        vec_t v;
        v.in = i; v.en = e; v.ack = a; v.n = n; v.ev = ev; v.code = c; v.ov = ov; v.pr = pr;
        return v;
    endfunction

    // Reference model: a press is described by the edge index it started / ended on,
    // and events fire when the elapsed edge count reaches the configured length.
    localparam int PH_NONE = 0, PH_FIRST = 1, PH_HELD = 2, PH_GAP = 3, PH_SECOND = 4;
    int         t = 0, t_press = 0, t_rel = 0, ph = PH_NONE;
    logic       m_valid = 1'b0, m_ov = 1'b0, m_pr = 1'b0;
    logic [1:0] m_code = 2'b00;

    task automatic model_reset();
        ph = PH_NONE; m_valid = 1'b0; m_ov = 1'b0; m_pr = 1'b0; m_code = 2'b00;
    endtask

    task automatic model_step(input logic i, input logic e, input logic a);
        logic       fire = 1'b0;
        logic [1:0] c    = 2'b00;
        t++;
        if (!e) ph = PH_NONE;
        else if (ph == PH_NONE) begin
            if (i) begin ph = PH_FIRST; t_press = t; end
        end else if (ph == PH_FIRST) begin
            if (!i) begin ph = PH_GAP; t_rel = t; end
            else if (t - t_press == LONG_N) begin fire = 1'b1; c = 2'b10; ph = PH_HELD; end
        end else if (ph == PH_HELD) begin
            if (!i) ph = PH_NONE;
        end else if (ph == PH_GAP) begin
            if (i) ph = PH_SECOND;
            else if (t - t_rel == GAP_N) begin fire = 1'b1; c = 2'b01; ph = PH_NONE; end
        end else begin
            if (!i) begin fire = 1'b1; c = 2'b11; ph = PH_NONE; end
        end
        if (fire) begin
            if (m_valid && !a) m_ov = 1'b1;
            else if (m_valid)  m_ov = 1'b0;
            m_valid = 1'b1;
            m_code  = c;
        end else if (m_valid && a) begin
            m_valid = 1'b0; m_code = 2'b00; m_ov = 1'b0;
        end
        m_pr = i;
    endtask

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {pr,ov,valid,code}=%b expected %b at t=%0t", name, got, exp,
                     $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {pressed, overrun, event_valid, event_code};
    endfunction

    // Called at posedge+1; drives inputs for one edge, then checks one unit after it.
    task automatic cycle(input logic i, input logic e, input logic a);
        in_sig = i; en = e; event_ack = a;
        @(posedge sys_clk);
        model_step(i, e, a);
        #1;
        chk("model", outs(), {m_pr, m_ov, m_valid, m_code});
    endtask

    initial begin
        // Reset values, then async reset in the middle of a press with an event pending.
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_state", outs(), 5'b00000);
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 1'b1, 1'b0);
        repeat (41) cycle(1'b0, 1'b1, 1'b0);
        chk("pre_reset_short", outs(), 5'b00101);
        repeat (50) cycle(1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", outs(), 5'b00000);
        model_reset();
        in_sig = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        repeat (60) cycle(1'b0, 1'b1, 1'b0);
        chk("no_event_after_reset", outs(), 5'b00000);

        // in, en, ack, cycles, expected valid, code, overrun, pressed after the last cycle
        tbl.push_back(mk(0, 1, 0,   5, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0,  30, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,  40, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0,   1, 1, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 0,   5, 1, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 1,   1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 100, 0, 2'b00, 0, 1));
        tbl.push_back(mk(1, 1, 0,   1, 1, 2'b10, 0, 1));
        tbl.push_back(mk(1, 1, 1,   1, 0, 2'b00, 0, 1));
        tbl.push_back(mk(1, 1, 0, 198, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,  45, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0,  99, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,  40, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0,   1, 1, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 1,   1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0,  20, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,  40, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0,  10, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,   1, 1, 2'b11, 0, 0));
        tbl.push_back(mk(0, 1, 1,   1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0,  20, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,  41, 1, 2'b01, 0, 0));
        tbl.push_back(mk(1, 1, 1,   1, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,   1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0,  40, 1, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 1,   1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0,   5, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,  41, 1, 2'b01, 0, 0));
        tbl.push_back(mk(1, 1, 0, 100, 1, 2'b01, 0, 1));
        tbl.push_back(mk(1, 1, 0,   1, 1, 2'b10, 1, 1));
        tbl.push_back(mk(0, 1, 0,   1, 1, 2'b10, 1, 0));
        tbl.push_back(mk(1, 1, 0,   5, 1, 2'b10, 1, 1));
        tbl.push_back(mk(0, 1, 0,  40, 1, 2'b10, 1, 0));
        tbl.push_back(mk(0, 1, 1,   1, 1, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 1,   1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 1,   3, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0,   5, 0, 2'b00, 0, 1));
        tbl.push_back(mk(0, 1, 0,  41, 1, 2'b01, 0, 0));
        tbl.push_back(mk(1, 1, 0,  20, 1, 2'b01, 0, 1));
        tbl.push_back(mk(0, 1, 0,  20, 1, 2'b01, 0, 0));
        tbl.push_back(mk(1, 1, 0,   5, 1, 2'b01, 0, 1));
        tbl.push_back(mk(1, 0, 0,   5, 1, 2'b01, 0, 1));
        tbl.push_back(mk(0, 0, 0,   3, 1, 2'b01, 0, 0));
        tbl.push_back(mk(1, 0, 0,   3, 1, 2'b01, 0, 1));
        tbl.push_back(mk(1, 1, 0, 100, 1, 2'b01, 0, 1));
        tbl.push_back(mk(1, 1, 0,   1, 1, 2'b10, 1, 1));
        tbl.push_back(mk(0, 1, 1,   1, 0, 2'b00, 0, 0));

        foreach (tbl[k]) begin
            string nm;
            repeat (tbl[k].n) cycle(tbl[k].in, tbl[k].en, tbl[k].ack);
            nm = $sformatf("table_row_%0d", k);
            chk(nm, outs(), {tbl[k].pr, tbl[k].ov, tbl[k].ev, tbl[k].code});
        end

        // Random press/release runs with occasional disable and random acks.
        begin
            logic lvl = 1'b0;
            for (int s = 0; s < 70; s++) begin
                int   len;
                logic e;
                lvl = ~lvl;
                len = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 130 : 45);
                e   = ($urandom_range(0, 9) != 0);
                for (int c = 0; c < len; c++)
                    cycle(lvl, e, ($urandom_range(0, 3) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
